// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: opcodes, instruction
// field positions, sequencer state encoding and the ALU-op decode helper.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } seq_state_t;

  function automatic logic is_alu_op(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INC, OP_DEC: is_alu_op = 1'b1;
      default:                                       is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_fetch.sv
// Instruction fetch handshake: requests while the sequencer sits in FETCH and
// captures the instruction word into IR on the acknowledge cycle.
module alu_seq_fetch #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         ir,
  output logic                fetch_done
);

  logic [15:0] ir_r;

  // Gating with reset makes the request drop the instant reset asserts.
  assign imem_req   = fetch_en & ~reset;
  assign imem_addr  = pc;
  assign fetch_done = imem_req & imem_ack;
  assign ir         = ir_r;

  // Instruction register, loaded only on an acknowledged request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_r <= 16'h0000;
    end else if (fetch_done) begin
      ir_r <= imem_data;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit CPU (fetch/decode/execute/write-back).
// Define ALU_SEQ_ICOUNT_EN to add the instr_count retired-instruction counter.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(8'h00)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [3:0]          alu_opcode,
  input  logic                alu_zero,
  output logic [1:0]          rf_raddr_a,
  output logic [1:0]          rf_raddr_b,
  output logic [1:0]          rf_waddr,
  output logic                rf_we,
  output logic                rf_wsel,
  output logic [7:0]          rf_wimm,
  output logic                z_flag,
  output logic                halted,
  output logic                illegal_op
`ifdef ALU_SEQ_ICOUNT_EN
  ,
  output logic [15:0]         instr_count
`endif
);

  seq_state_t          state_r, state_next_s;
  logic [PC_WIDTH-1:0] pc_r, pc_inc_s, jump_tgt_s;
  logic [15:0]         ir_s;
  logic                fetch_en_s, fetch_done_s;

  assign fetch_en_s = (state_r == S_FETCH);
  assign pc_inc_s   = pc_r + PC_WIDTH'(1'b1);
  assign jump_tgt_s = PC_WIDTH'(ir_s[IMM_MSB:IMM_LSB]);

  alu_seq_fetch #(.PC_WIDTH(PC_WIDTH)) u_fetch (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en_s),
    .pc         (pc_r),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .ir         (ir_s),
    .fetch_done (fetch_done_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_next_s;
  end

  // Next-state decode; HALT is absorbing until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (fetch_done_s) state_next_s = S_DECODE;
        else              state_next_s = S_FETCH;
      end
      S_DECODE: state_next_s = S_EXECUTE;
      S_EXECUTE: begin
        if (alu_opcode == OP_HALT)                             state_next_s = S_HALT;
        else if ((alu_opcode == OP_LDI) || is_alu_op(alu_opcode)) state_next_s = S_WRITEBACK;
        else                                                   state_next_s = S_FETCH;
      end
      S_WRITEBACK: state_next_s = S_FETCH;
      S_HALT:      state_next_s = S_HALT;
      default:     state_next_s = S_FETCH;
    endcase
  end

  // Datapath control registers, PC and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      alu_opcode <= 4'h0;
      rf_raddr_a <= 2'd0;
      rf_raddr_b <= 2'd0;
      rf_waddr   <= 2'd0;
      rf_we      <= 1'b0;
      rf_wsel    <= 1'b0;
      rf_wimm    <= 8'h00;
      z_flag     <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      case (state_r)
        S_DECODE: begin
          alu_opcode <= ir_s[OP_MSB:OP_LSB];
          rf_raddr_a <= ir_s[RD_MSB:RD_LSB];
          rf_raddr_b <= ir_s[RS_MSB:RS_LSB];
          rf_waddr   <= ir_s[RD_MSB:RD_LSB];
        end
        S_EXECUTE: begin
          case (alu_opcode)
            OP_NOP: pc_r <= pc_inc_s;
            OP_LDI: begin
              rf_we   <= 1'b1;
              rf_wsel <= 1'b1;
              rf_wimm <= ir_s[IMM_MSB:IMM_LSB];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_INC, OP_DEC: begin
              z_flag  <= alu_zero;
              rf_we   <= 1'b1;
              rf_wsel <= 1'b0;
            end
            OP_JMP:  pc_r   <= jump_tgt_s;
            // JZ tests the ALU's pass-through of rd, not the stored flag.
            OP_JZ:   pc_r   <= alu_zero ? jump_tgt_s : pc_inc_s;
            OP_HALT: halted <= 1'b1;
            default: begin
              illegal_op <= 1'b1;
              pc_r       <= pc_inc_s;
            end
          endcase
        end
        S_WRITEBACK: pc_r <= pc_inc_s;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ICOUNT_EN
  // Retired-instruction counter; HALT never re-enters FETCH so it freezes there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 16'h0000;
    end else if (((state_r == S_EXECUTE) || (state_r == S_WRITEBACK)) &&
                 (state_next_s == S_FETCH)) begin
      instr_count <= instr_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with fetch/write scoreboards.
// Also builds with ALU_SEQ_ICOUNT_EN to check the instruction counter.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  alu_opcode;
  logic        alu_zero;
  logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, rf_wsel;
  logic [7:0]  rf_wimm;
  logic        z_flag, halted, illegal_op;
`ifdef ALU_SEQ_ICOUNT_EN
  logic [15:0] instr_count;
`endif

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .alu_opcode (alu_opcode),
    .alu_zero   (alu_zero),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_waddr   (rf_waddr),
    .rf_we      (rf_we),
    .rf_wsel    (rf_wsel),
    .rf_wimm    (rf_wimm),
    .z_flag     (z_flag),
    .halted     (halted),
    .illegal_op (illegal_op)
`ifdef ALU_SEQ_ICOUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] rd;
    logic [1:0] rs;
    logic       wsel;
    logic [7:0] imm;
    logic [3:0] op;
  } wr_t;

  logic [7:0] addr_q[$];
  wr_t        wr_q[$];
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         total_cnt = 0;
  logic       model_z = 1'b0;
  int         model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_is_alu(input logic [3:0] op);
    return (op == 4'h3) || (op == 4'h4) || (op == 4'h5) || (op == 4'h6) ||
           (op == 4'hA) || (op == 4'hB);
  endfunction

  function automatic logic tb_is_illegal(input logic [3:0] op);
    return (op == 4'h2) || (op == 4'h8) || (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Fetch one instruction, predict its effects, then follow it to retirement.
  task automatic exec(input logic [15:0] instr, input int ack_wait, input logic zero_val);
    logic [3:0] op;
    logic [7:0] cur, nxt;
    logic       stable, done;
    int         cycles, we_seen, ill_seen, guard;
    wr_t        w;
    op = instr[15:12];
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    cur = (addr_q.size() > 0) ? addr_q.pop_front() : 8'hxx;
    check("fetch_addr", 32'(imem_addr), 32'(cur));
    if (tb_is_alu(op) || op == 4'h1) begin
      w.rd = instr[11:10]; w.rs = instr[9:8]; w.wsel = (op == 4'h1);
      w.imm = instr[7:0]; w.op = op;
      wr_q.push_back(w);
    end
    if (op == 4'h7)      nxt = instr[7:0];
    else if (op == 4'h9) nxt = zero_val ? instr[7:0] : cur + 8'd1;
    else                 nxt = cur + 8'd1;
    if (op != 4'hF) begin
      addr_q.push_back(nxt);
      model_cnt++;
    end
    if (tb_is_alu(op)) model_z = zero_val;

    cycles = 0;
    stable = 1'b1;
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack = 1'b0;
      tick();
      cycles++;
      if (imem_req !== 1'b1 || imem_addr !== cur) stable = 1'b0;
    end
    check("addr_stable", 32'(stable), 32'd1);
    imem_ack  = 1'b1;
    imem_data = instr;
    tick();
    cycles++;
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    alu_zero  = zero_val;

    we_seen = 0; ill_seen = 0; done = 1'b0;
    while (!done && cycles < 30) begin
      if (rf_we === 1'b1) begin
        we_seen++;
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check("wr_waddr", 32'(rf_waddr), 32'(w.rd));
          check("wr_raddr_a", 32'(rf_raddr_a), 32'(w.rd));
          check("wr_raddr_b", 32'(rf_raddr_b), 32'(w.rs));
          check("wr_wsel", 32'(rf_wsel), 32'(w.wsel));
          check("wr_opcode", 32'(alu_opcode), 32'(w.op));
          if (w.wsel) check("wr_wimm", 32'(rf_wimm), 32'(w.imm));
        end
      end
      if (illegal_op === 1'b1) ill_seen++;
      if ((op == 4'hF) ? (halted === 1'b1) : (imem_req === 1'b1)) done = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
    check("retire_timeout", 32'(done), 32'd1);
    if (op != 4'hF) begin
      check("latency", 32'(cycles),
            32'(((tb_is_alu(op) || op == 4'h1) ? 4 : 3) + ack_wait));
    end else begin
      check("halt_req", 32'(imem_req), 32'd0);
    end
    check("we_pulses", 32'(we_seen), 32'((tb_is_alu(op) || op == 4'h1) ? 1 : 0));
    check("illegal_pulses", 32'(ill_seen), 32'(tb_is_illegal(op) ? 1 : 0));
    check("z_flag", 32'(z_flag), 32'(model_z));
`ifdef ALU_SEQ_ICOUNT_EN
    check("instr_count", 32'(instr_count), 32'(model_cnt));
`endif
  endtask

  initial begin
    int req_seen;
    reset     = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    alu_zero  = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_wimm", 32'(rf_wimm), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_z", 32'(z_flag), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    reset = 1'b0;
    #1;
    addr_q.push_back(8'h00);

    exec(16'h1405, 3, 1'b0);  // LDI r1,0x05 with a 3-cycle ack delay
    exec(16'hB400, 0, 1'b0);  // DEC r1
    exec(16'h4A00, 0, 1'b1);  // SUB r2,r2 -> zero
    exec(16'h10AA, 0, 1'b0);  // LDI r0,0xAA leaves z_flag alone
    exec(16'h9840, 0, 1'b1);  // JZ r2,0x40 taken
    exec(16'h9010, 1, 1'b0);  // JZ r0,0x10 not taken
    exec(16'h6D00, 0, 1'b0);  // OR r3,r1
    exec(16'h70FF, 0, 1'b0);  // JMP 0xFF
    exec(16'h0000, 0, 1'b0);  // NOP at 0xFF wraps to 0x00
    exec(16'h5600, 2, 1'b1);  // AND r1,r2 -> z_flag=1

    // ADD interrupted by reset during its write-back cycle.
    check("add_fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
    imem_ack  = 1'b1;
    imem_data = 16'h3600;
    alu_zero  = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    check("add_wb_we", 32'(rf_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rstwb_we", 32'(rf_we), 32'd0);
    check("rstwb_req", 32'(imem_req), 32'd0);
    check("rstwb_pc", 32'(imem_addr), 32'h00);
    check("rstwb_z", 32'(z_flag), 32'd0);
`ifdef ALU_SEQ_ICOUNT_EN
    check("rstwb_count", 32'(instr_count), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;
    alu_zero = 1'b0;
    #1;
    addr_q.delete();
    wr_q.delete();
    addr_q.push_back(8'h00);
    model_z   = 1'b0;
    model_cnt = 0;

    exec(16'hC123, 0, 1'b0);  // undefined opcode 1100
    exec(16'hF000, 0, 1'b0);  // HALT

    // Acknowledges while halted must be ignored.
    req_seen = 0;
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req === 1'b1) req_seen++;
    end
    imem_ack = 1'b0;
    check("halt_req_cycles", 32'(req_seen), 32'd0);
    check("halt_pc", 32'(imem_addr), 32'h01);
    check("halt_stays", 32'(halted), 32'd1);
`ifdef ALU_SEQ_ICOUNT_EN
    check("halt_count", 32'(instr_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit for the 8-bit CPU. It fetches 16-bit instructions over a request/acknowledge bus, decodes them, drives the ALU opcode and register-file addresses, and sequences write-back, the zero flag and program-counter updates. It sits between instruction memory, the register file and the ALU, and is the only block that sequences the datapath.

## Interface
- `PC_WIDTH`, 8: program counter and instruction address width.
- `RESET_PC`, 8'h00: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_WIDTH: fetch address, equal to the PC.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_data` in 16: instruction. [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/target.
- `alu_opcode` out 4: opcode presented to the ALU.
- `alu_zero` in 1: ALU zero output.
- `rf_raddr_a` out 2: ALU operand_a source, always rd.
- `rf_raddr_b` out 2: ALU operand_b source, always rs.
- `rf_waddr` out 2: write-back destination, always rd.
- `rf_we` out 1: register-file write strobe.
- `rf_wsel` out 1: write data select. 0 = ALU result, 1 = immediate.
- `rf_wimm` out 8: immediate for LDI.
- `z_flag` out 1: architectural zero flag.
- `halted` out 1: core stopped.
- `illegal_op` out 1: one-cycle pulse on an undefined opcode.
- `instr_count` out 16: retired-instruction counter. Present only with `ALU_SEQ_ICOUNT_EN`.

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT. Reset enters FETCH.
- **FETCH**
  - `imem_req`=1 with `imem_addr`=PC, held stable until `imem_ack` is sampled high.
  - In the ack cycle: instruction latched into IR, `imem_req` deasserts, go to DECODE.
- **DECODE**
  - Opcode registered to `alu_opcode`. rd/rs registered to the read and write addresses.
  - Go to EXECUTE.
- **EXECUTE**: `alu_zero` sampled at the end of the cycle. Action by opcode:
  - 0000 NOP: PC+1, go to FETCH.
  - 0001 LDI: go to WRITEBACK with `rf_wsel`=1 and `rf_wimm`=imm.
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 1010 INC, 1011 DEC:
    - `z_flag` <= `alu_zero`.
    - Go to WRITEBACK with `rf_wsel`=0.
  - 0111 JMP: PC <= target, go to FETCH.
  - 1001 JZ: the ALU passes rd through. If `alu_zero`, PC <= target; else PC+1. `z_flag` unchanged. Go to FETCH.
  - 1111 HALT: go to HALT.
  - 0010, 1000, 1100, 1101, 1110: `illegal_op` pulses for one cycle, executed as NOP.
- **WRITEBACK**: `rf_we`=1 for exactly one cycle, PC+1, go to FETCH.
- **HALT**
  - `halted`=1, `imem_req`=0.
  - Leaves only by reset.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFF+1 = 0x00. Jump targets are zero-extended or truncated to PC_WIDTH.
- LDI does not update `z_flag`.

## Timing
- Reset values:
  - PC=RESET_PC; IR, `alu_opcode` and `rf_wimm` = 0.
  - Register-file addresses, `rf_we`, `rf_wsel`, `z_flag`, `halted`, `illegal_op` and `instr_count` = 0.
  - `imem_req`=1 from the first cycle after reset release.
- Latency with `imem_ack` returned in the first request cycle:
  - ALU ops and LDI: 4 cycles.
  - NOP, JMP and JZ: 3 cycles.
  - Each extra wait cycle on `imem_ack` adds 1.
- `imem_ack` is ignored whenever `imem_req`=0.
- A reset asserted mid-fetch or mid-writeback drops `imem_req` and `rf_we` asynchronously. The write is lost and no partial state persists.
- `z_flag` changes only at the end of EXECUTE. An instruction sees the flag left by its predecessors.

## Configuration
- `ALU_SEQ_ICOUNT_EN` defined:
  - `instr_count` port exists.
  - Increments by 1 on each transition into FETCH from EXECUTE or WRITEBACK. Illegal opcodes count.
  - Wraps 0xFFFF to 0x0000 and freezes in HALT.
- Undefined: the port and counter are absent and the behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode localparams: OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JMP, OP_JZ, OP_INC, OP_DEC, OP_HALT.
  - Instruction field bit positions.
  - State encoding typedef `seq_state_t`.
- The decode function `is_alu_op(opcode)` lives in the package.
- One sub-module, `alu_seq_fetch`, owns the request/ack handshake and IR capture. The FSM and PC stay in `alu_sequencer`.

## Test plan
- Reset release, `imem_ack` delayed 3 cycles → `imem_addr`=0x00 held stable for 4 cycles, IR captured in the ack cycle.
- LDI r1,0x05 then DEC r1 → `rf_we` pulses once per instruction; DEC has `alu_opcode`=1011, `rf_waddr`=1, `rf_wsel`=0, and sets `z_flag`=0.
- SUB r2,r2 (ALU returns `alu_zero`=1) then JZ r2,0x40 → `z_flag`=1; next `imem_addr`=0x40, and the JZ takes 3 cycles.
- JMP 0xFF then NOP → fetch at 0xFF, then 0x00 (PC wrap).
- Opcode 1100 then HALT → `illegal_op` pulses once, PC advances; after HALT, `halted`=1, `imem_req` stays 0, and with `ALU_SEQ_ICOUNT_EN` `instr_count` freezes at 1.
- Reset asserted during WRITEBACK of ADD → `rf_we` drops the same cycle, PC=RESET_PC, `z_flag`=0.
